// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with clock-enable prescaler.
// Wrap/saturate bounds, parallel load, hold, terminal-count pulse.
module updown_counter_param #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8,
  parameter int DIV     = 50000000,
  parameter int PW      = 26
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en,
  input  logic             switch,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  localparam logic [PW-1:0]    RELOAD = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] TOP    = WIDTH'(MODULUS - 1);

  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] step_val;
  logic             at_bound;
  logic [WIDTH-1:0] load_clamp;

  // Next count for an update edge, plus bound detection in the sampled direction
  always_comb begin
    step_val = count;
    at_bound = 1'b0;
    if (switch) begin
      if (count == TOP) begin
        at_bound = 1'b1;
        step_val = sat_mode ? TOP : '0;
      end else begin
        step_val = count + 1'b1;
      end
    end else begin
      if (count == '0) begin
        at_bound = 1'b1;
        step_val = sat_mode ? '0 : TOP;
      end else begin
        step_val = count - 1'b1;
      end
    end
  end

  // Out-of-range load values are pinned to the top state
  always_comb begin
    load_clamp = load_val;
    if (load_val > TOP) load_clamp = TOP;
  end

  // Prescaler, count and pulse registers; load outranks the enable path
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      count <= '0;
      presc <= RELOAD;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_clamp;
      presc <= RELOAD;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (!en) begin
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (presc == '0) begin
      presc <= RELOAD;
      count <= step_val;
      tick  <= 1'b1;
      tc    <= at_bound;
    end else begin
      presc <= presc - 1'b1;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param.
// Main instance MODULUS=6 DIV=4, second instance DIV=1.
module tb_updown_counter_param;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       sw;
  logic       sat;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] count;
  logic       tick;
  logic       tc;
  logic [2:0] count1;
  logic       tick1;
  logic       tc1;

  int n_tests = 0;
  int n_fail  = 0;

  updown_counter_param #(
    .WIDTH(3), .MODULUS(6), .DIV(4), .PW(3)
  ) dut (
    .clkin(clk), .reset(rst_n), .en(en), .switch(sw),
    .sat_mode(sat), .load(load), .load_val(load_val),
    .count(count), .tick(tick), .tc(tc)
  );

  updown_counter_param #(
    .WIDTH(3), .MODULUS(6), .DIV(1), .PW(1)
  ) dut1 (
    .clkin(clk), .reset(rst_n), .en(en), .switch(sw),
    .sat_mode(sat), .load(load), .load_val(load_val),
    .count(count1), .tick(tick1), .tc(tc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one full DIV=4 period starting with prescaler at DIV-1
  task automatic period(input string tag, input int c, input bit t);
    for (int i = 0; i < 3; i++) begin
      step();
      check({tag, "_idle_tick"}, tick, 0);
    end
    step();
    check({tag, "_tick"}, tick, 1);
    check({tag, "_count"}, count, c);
    check({tag, "_tc"}, tc, t);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sw = 1'b1; sat = 1'b0;
    load = 1'b0; load_val = '0;
    repeat (3) step();
    check("rst_count", count, 0);
    check("rst_tick", tick, 0);
    check("rst_tc", tc, 0);

    rst_n = 1'b1; en = 1'b1;
    period("up1", 1, 0);
    period("up2", 2, 0);
    period("up3", 3, 0);
    period("up4", 4, 0);
    period("up5", 5, 0);
    period("upwrap", 0, 1);

    period("up1b", 1, 0);
    period("up2b", 2, 0);
    sw = 1'b0;
    period("dn1", 1, 0);
    period("dn0", 0, 0);
    period("dnwrap", 5, 1);

    step(); step();
    sw = 1'b1;
    step();
    check("midsw_tick", tick, 0);
    check("midsw_hold", count, 5);
    step();
    check("midsw_step", count, 0);
    check("midsw_tc", tc, 1);

    period("s1", 1, 0);
    period("s2", 2, 0);
    period("s3", 3, 0);
    period("s4", 4, 0);
    sat = 1'b1;
    period("s5", 5, 0);
    period("sat_a", 5, 1);
    period("sat_b", 5, 1);
    sw = 1'b0;
    period("sat_dn", 4, 0);

    step(); step(); step();
    load = 1'b1; load_val = 3'd3;
    step();
    load = 1'b0;
    check("ld_count", count, 3);
    check("ld_tick", tick, 0);
    check("ld_tc", tc, 0);
    period("ld_next", 2, 0);
    load = 1'b1; load_val = 3'd7;
    step();
    load = 1'b0;
    check("ld_clamp", count, 5);
    period("ld_clamp_next", 4, 0);

    step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_tick", tick, 0);
    end
    check("hold_count", count, 4);
    en = 1'b1;
    step();
    step();
    check("resume_early", tick, 0);
    step();
    check("resume_tick", tick, 1);
    check("resume_count", count, 3);

    sw = 1'b1; sat = 1'b0;
    period("pre_rst", 4, 0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_count", count, 0);
    check("async_tick", tick, 0);
    step();
    rst_n = 1'b1;

    for (int i = 1; i <= 7; i++) begin
      step();
      check("d1_tick", tick1, 1);
      check("d1_count", count1, i % 6);
      check("d1_tc", tc1, (i == 6) ? 1 : 0);
    end
    en = 1'b0;
    step();
    check("d1_hold_tick", tick1, 0);
    check("d1_hold_count", count1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
